w_iter_sequencer: RTL

W_ITER_SEQUENCER -- requirements
Module: w_iter_sequencer

---
 rtl/w_iter_sequencer_pkg.sv | 44 ++++
 rtl/w_iter_sequencer_slice_counter.sv | 34 +++
 rtl/w_iter_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/w_iter_sequencer_pkg.sv
// Shared encodings for the W-iteration sequencer and its datapath: FSM states,
// datapath STATE codes and the slice-count helper.
package w_iter_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StSweep = 3'd2,
    StUpper = 3'd3,
    StDrain = 3'd4,
    StDone  = 3'd5
  } seq_state_e;

  // STATE codes as seen by the datapath; IDLE and DONE also present 00 with dp_en low
  typedef enum logic [1:0] {
    DpDrain = 2'b00,
    DpSweep = 2'b01,
    DpLoad  = 2'b10,
    DpUpper = 2'b11
  } dp_state_e;

  typedef enum logic [1:0] {
    SliceClear = 2'd0,
    SliceStep  = 2'd1,
    SliceLast  = 2'd2
  } slice_op_e;

  localparam logic [8:0] MinWordBits = 9'd4;

  function automatic dp_state_e dp_code(seq_state_e st);
    case (st)
      StLoad:  return DpLoad;
      StSweep: return DpSweep;
      StUpper: return DpUpper;
      default: return DpDrain;
    endcase
  endfunction

  // Number of 4-bit slices covering a residue of the given width
  function automatic logic [6:0] slices_for(logic [8:0] bits);
    return bits[8:2] + {6'd0, |bits[1:0]};
  endfunction

endpackage

// File: rtl/w_iter_sequencer_slice_counter.sv
// Slice-index counter: derives max_cycle from the active residue width and
// steps the 4-bit slice index through LOAD, SWEEP and UPPER.
module w_iter_sequencer_slice_counter
  import w_iter_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  slice_op_e  op,
  input  logic [8:0] cnt_master,
  output logic [6:0] max_cycle,
  output logic [6:0] slice,
  output logic       last_sweep
);

  logic [6:0] slice_q;

  assign max_cycle  = slices_for(cnt_master);
  assign slice      = slice_q;
  // Only meaningful while sweeping, where max_cycle >= 2
  assign last_sweep = (slice_q == max_cycle - 7'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      slice_q <= 7'd0;
    end else begin
      case (op)
        SliceStep: slice_q <= slice_q + 7'd1;
        SliceLast: slice_q <= max_cycle - 7'd1;
        default:   slice_q <= 7'd0;
      endcase
    end
  end

endmodule

// File: rtl/w_iter_sequencer.sv
// Control sequencer for an online divider: walks LOAD/SWEEP/UPPER per digit,
// retries on datapath errors, drains for DELTA cycles and reports done/abort.
module w_iter_sequencer
  import w_iter_sequencer_pkg::*;
#(
  parameter int unsigned DELTA     = 3,  // must be >= 1
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] n_digits,
  input  logic [8:0] word_bits,
  input  logic       error_flag,
  output logic [1:0] state_code,
  output logic [8:0] cnt_master,
  output logic [6:0] computation_cycle,
  output logic       carry_feedback,
  output logic       q_load,
  output logic       dp_en,
  output logic       busy,
  output logic       done,
  output logic       abort,
  output logic [6:0] iter
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned DrainW = (DELTA > 1) ? $clog2(DELTA) : 1;

  seq_state_e        state_q, state_d;
  logic [6:0]        n_lat_q, n_lat_d;
  logic [8:0]        wb_lat_q, wb_lat_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [6:0]        iter_q, iter_d;
  logic [RetryW-1:0] retry_q, retry_d, retry_inc;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              abort_q, abort_d;

  dp_state_e         code_q;
  logic              dp_en_q, q_load_q, carry_q, busy_q, done_q;

  logic [6:0]        max_cycle;
  logic [6:0]        slice;
  logic              last_sweep;
  slice_op_e         slice_op;

  w_iter_sequencer_slice_counter slice_counter (
    .clk        (clk),
    .rst        (rst),
    .op         (slice_op),
    .cnt_master (cnt_q),
    .max_cycle  (max_cycle),
    .slice      (slice),
    .last_sweep (last_sweep)
  );

  always_comb begin
    state_d   = state_q;
    n_lat_d   = n_lat_q;
    wb_lat_d  = wb_lat_q;
    cnt_d     = cnt_q;
    iter_d    = iter_q;
    retry_d   = retry_q;
    drain_d   = drain_q;
    abort_d   = abort_q;
    retry_inc = retry_q + RetryW'(1);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_lat_d  = n_digits;
          wb_lat_d = (word_bits < MinWordBits) ? MinWordBits : word_bits;
          cnt_d    = 9'd4;
          iter_d   = 7'd0;
          retry_d  = '0;
          abort_d  = 1'b0;
          state_d  = (n_digits == 7'd0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        state_d = (max_cycle > 7'd1) ? StSweep : StUpper;
      end
      StSweep: begin
        if (last_sweep) state_d = StUpper;
      end
      StUpper: begin
        if (!error_flag) begin
          if (cnt_q < wb_lat_q) cnt_d = cnt_q + 9'd1;
          iter_d  = iter_q + 7'd1;
          retry_d = '0;
          drain_d = '0;
          state_d = (iter_q + 7'd1 == n_lat_q) ? StDrain : StLoad;
        end else begin
          retry_d = retry_inc;
          if (retry_inc == RetryW'(MAX_RETRY)) begin
            abort_d = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StDrain: begin
        if (drain_q == DrainW'(DELTA - 1)) state_d = StDone;
        else drain_d = drain_q + DrainW'(1);
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StUpper) slice_op = SliceLast;
    else if (state_d == StSweep && state_q == StSweep) slice_op = SliceStep;
    else slice_op = SliceClear;
  end

  // Outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      n_lat_q  <= '0;
      wb_lat_q <= '0;
      cnt_q    <= '0;
      iter_q   <= '0;
      retry_q  <= '0;
      drain_q  <= '0;
      abort_q  <= 1'b0;
      code_q   <= DpDrain;
      dp_en_q  <= 1'b0;
      q_load_q <= 1'b0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_lat_q  <= n_lat_d;
      wb_lat_q <= wb_lat_d;
      cnt_q    <= cnt_d;
      iter_q   <= iter_d;
      retry_q  <= retry_d;
      drain_q  <= drain_d;
      abort_q  <= abort_d;
      code_q   <= dp_code(state_d);
      dp_en_q  <= (state_d != StIdle) && (state_d != StDone);
      q_load_q <= (state_d == StLoad);
      carry_q  <= (state_d == StSweep) && (state_q == StLoad);
      busy_q   <= (state_d != StIdle);
      done_q   <= (state_d == StDone);
    end
  end

  assign state_code        = code_q;
  assign cnt_master        = cnt_q;
  assign computation_cycle = slice;
  assign carry_feedback    = carry_q;
  assign q_load            = q_load_q;
  assign dp_en             = dp_en_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign abort             = abort_q;
  assign iter              = iter_q;

endmodule
